cordic_rotation_core: RTL and testbench
=======================================

# cordic_rotation_core

Iterative fixed-point CORDIC engine in rotation mode. It takes a pre-reduced first-quadrant angle and produces cos/sin magnitudes as IEEE-754 single-precision values, with quadrant sign flags passed through. It sits directly upstream of the post-processing stage, which applies the flags by flipping the sign bits. One operation is in flight at a time, with a start/busy/done handshake.

## Interface
- `ITER`, default 24: number of micro-rotations; legal range 16..30.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `angle` input 32: unsigned Q2.30 angle, in radians, nominally in [0, π/2].
- `cos_neg_in` input 1: quadrant flag, captured with `angle`.
- `sin_neg_in` input 1: quadrant flag, captured with `angle`.
- `busy` output 1: high from the load edge until `done` is asserted.
- `done` output 1: one-cycle pulse; results valid from this cycle.
- `cordic_x` output 32: IEEE-754 single-precision cos magnitude; sign bit is always 0.
- `cordic_y` output 32: IEEE-754 single-precision sin magnitude; sign bit is always 0.
- `cos_neg` output 1: captured `cos_neg_in`, held with the results.
- `sin_neg` output 1: captured `sin_neg_in`, held with the results.

## Operation
- **FSM states:**
  - IDLE → ITER when `start` is high; this edge is the load edge.
  - ITER → CONV after iteration `ITER-1`.
  - CONV → IDLE unconditionally; `done` is asserted for this cycle only.
- **Load:**
  - x = K_INV = 0x26DD3B6A (0.607252935 in Q2.30), y = 0.
  - z = min(`angle`, PI_2), with PI_2 = 0x6487ED51. Out-of-range angles saturate.
  - Flags are captured on this edge.
- **Iteration i (0..ITER-1):**
  - d = +1 if z ≥ 0 (signed 32-bit), otherwise −1.
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·ATAN[i].
  - All values are signed 32-bit with arithmetic shifts. Updates use the pre-edge values of x and y.
- **CONV step:**
  - Any negative x or y (rounding undershoot) is clamped to 0.
  - Each value is then converted to float by `cordic_fix2float`.
  - Conversion of v: if v = 0 the result is 0x00000000. Otherwise p = MSB index, exponent = 127 + p − 30, mantissa = the 23 bits below the MSB. Missing low bits are zero-filled; excess bits are truncated, with no rounding.
- **Held outputs:** `cordic_x`, `cordic_y`, `cos_neg` and `sin_neg` register on the CONV edge and hold until the next CONV edge.
- **Ignored requests:** `start` while busy is ignored and not queued.
- **Back-to-back:** `start` high in the cycle `done` is asserted is not accepted, because the FSM is still in CONV. It is accepted in the following cycle.

## Timing
- The load edge is edge 0. Iterations occur on edges 1..ITER. CONV registers the results on edge ITER+1.
- `done` is high in the cycle following edge ITER+1, which is ITER+2 cycles after `start` was sampled. With the default, that is 26.
- `busy` is high from after edge 0 until the cycle in which `done` is asserted. It is low in the cycle `done` is high.
- **Reset values:**
  - All outputs are 0.
  - FSM is in IDLE.
  - x, y, z and the iteration counter are 0.
- Reset mid-operation aborts the operation with no `done` pulse. Outputs are zeroed on the next edge.
- Simultaneous `rst` and `start`: reset wins.

## Structure
- **Package `cordic_pkg`:**
  - ATAN table: atan(2^-i)·2^30 rounded, for i = 0..30; e.g. ATAN[0] = 0x3243F6A9.
  - K_INV and PI_2.
  - Q-format width constants.
  - FSM state typedef.
- **Sub-module `cordic_fix2float`:** combinational converter, 32-bit Q2.30 unsigned to IEEE-754 single, built on a leading-one detector. It is instantiated twice.

## Test plan
- **angle 0x00000000, flags 0:**
  - `done` at cycle 26.
  - `cordic_x` within 2^-20 of 1.0 (near 0x3F800000).
  - `cordic_y` < 2^-20.
  - `cos_neg` = `sin_neg` = 0.
- **angle 0x3243F6A8 (π/4), flags cos=1, sin=0:** both outputs within 2^-20 of 0x3F3504F3; `cos_neg` = 1, `sin_neg` = 0.
- **angle 0xFFFFFFFF:**
  - Saturates to π/2.
  - `cordic_y` ≈ 1.0; `cordic_x` < 2^-20 and non-negative, with sign bit 0.
- **Request during busy:** `start` pulsed at cycles 5 and 10 with a different angle. Exactly one `done`, and the results match the first angle.
- **Reset mid-operation:** `rst` asserted at cycle 12. No `done`; outputs are 0. A new `start` after reset completes normally in 26 cycles.
- **Back-to-back requests:** `start` held high continuously. `done` pulses every 27 cycles, and `busy` drops exactly in each `done` cycle.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module : cordic_pkg
// Brief  : Shared constants, arctangent table and FSM state type for the
//          rotation-mode CORDIC core.
// Rev    : 1.0  initial release
// ============================================================================
package cordic_pkg;

    localparam int Q_W      = 32;
    localparam int Q_FRAC   = 30;
    localparam int FLT_BIAS = 127;
    localparam int CNT_W    = 5;

    localparam logic [Q_W-1:0] K_INV = 32'h26DD3B6A;
    localparam logic [Q_W-1:0] PI_2  = 32'h6487ED51;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_CONV = 2'd2
    } state_t;

    // atan(2^-i) scaled by 2^30, rounded; beyond i = 10 it is exactly 2^(30-i)
    function automatic logic [Q_W-1:0] atan_lut(input logic [CNT_W-1:0] idx);
        logic [Q_W-1:0] r;
        case (idx)
            5'd0:    r = 32'h3243F6A9;
            5'd1:    r = 32'h1DAC6705;
            5'd2:    r = 32'h0FADBAFD;
            5'd3:    r = 32'h07F56EA7;
            5'd4:    r = 32'h03FEAB77;
            5'd5:    r = 32'h01FFD55C;
            5'd6:    r = 32'h00FFFAAB;
            5'd7:    r = 32'h007FFF55;
            5'd8:    r = 32'h003FFFEB;
            5'd9:    r = 32'h001FFFFD;
            5'd31:   r = 32'h00000000;
            default: r = 32'h40000000 >> idx;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_rotation_core_if.sv
`default_nettype none
// ============================================================================
// Module : cordic_rotation_core_if
// Brief  : Start/busy/done request and result bundle of the CORDIC core.
// Rev    : 1.0  initial release
// ============================================================================
interface cordic_rotation_core_if;

    logic        start;
    logic [31:0] angle;
    logic        cos_neg_in;
    logic        sin_neg_in;
    logic        busy;
    logic        done;
    logic [31:0] cordic_x;
    logic [31:0] cordic_y;
    logic        cos_neg;
    logic        sin_neg;

    modport master (
        output start, angle, cos_neg_in, sin_neg_in,
        input  busy, done, cordic_x, cordic_y, cos_neg, sin_neg
    );

    modport slave (
        input  start, angle, cos_neg_in, sin_neg_in,
        output busy, done, cordic_x, cordic_y, cos_neg, sin_neg
    );

endinterface
`default_nettype wire

// File: rtl/cordic_fix2float.sv
`default_nettype none
// ============================================================================
// Module : cordic_fix2float
// Brief  : Combinational unsigned Q2.30 to IEEE-754 single converter,
//          truncating, built around a leading-one detector.
// Rev    : 1.0  initial release
// ============================================================================
module cordic_fix2float
    import cordic_pkg::*;
(
    input  logic [Q_W-1:0] fix_i,
    output logic [31:0]    flt_o
);

    logic [CNT_W-1:0] w_msb;
    logic [22:0]      w_man;
    logic [7:0]       w_exp;

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < Q_W; i++) begin
            if (fix_i[i]) begin
                w_msb = CNT_W'(i);
            end
        end
    end

    // Shifting the padded word right by the MSB index lands the 23 bits below
    // the leading one at [22:0], zero-filled when fewer bits exist.
    assign w_man = 23'({fix_i, 23'b0} >> w_msb);
    assign w_exp = 8'(FLT_BIAS - Q_FRAC) + {3'b000, w_msb};
    assign flt_o = (fix_i == '0) ? 32'h0000_0000 : {1'b0, w_exp, w_man};

endmodule
`default_nettype wire

// File: rtl/cordic_rotation_core.sv
`default_nettype none
// ============================================================================
// Module : cordic_rotation_core
// Brief  : Iterative rotation-mode CORDIC producing cos/sin magnitudes as
//          IEEE-754 singles, one operation in flight, flags passed through.
// Rev    : 1.0  initial release
// ============================================================================
module cordic_rotation_core
    import cordic_pkg::*;
#(
    parameter int ITER = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    cordic_rotation_core_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic signed [Q_W-1:0]  x_q, y_q, z_q;
    logic signed [Q_W-1:0]  x_d, y_d, z_d;
    logic                   cneg_cap_q, sneg_cap_q;
    logic                   busy_q, done_q;
    logic [31:0]            fx_q, fy_q;
    logic                   cos_neg_q, sin_neg_q;

    logic signed [Q_W-1:0]  w_x_sh, w_y_sh, w_atan;
    logic [Q_W-1:0]         w_x_pos, w_y_pos, w_z_load;
    logic [31:0]            w_fx, w_fy;

    assign w_x_sh   = x_q >>> cnt_q;
    assign w_y_sh   = y_q >>> cnt_q;
    assign w_atan   = $signed(atan_lut(cnt_q));
    assign w_z_load = (bus.angle > PI_2) ? PI_2 : bus.angle;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (!z_q[Q_W-1]) begin
            x_d = x_q - w_y_sh;
            y_d = y_q + w_x_sh;
            z_d = z_q - w_atan;
        end else begin
            x_d = x_q + w_y_sh;
            y_d = y_q - w_x_sh;
            z_d = z_q + w_atan;
        end
    end

    // Final micro-rotations can undershoot zero by a few LSBs.
    assign w_x_pos = x_q[Q_W-1] ? '0 : x_q;
    assign w_y_pos = y_q[Q_W-1] ? '0 : y_q;

    cordic_fix2float u_f2f_x (.fix_i(w_x_pos), .flt_o(w_fx));
    cordic_fix2float u_f2f_y (.fix_i(w_y_pos), .flt_o(w_fy));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            cneg_cap_q <= 1'b0;
            sneg_cap_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fx_q       <= '0;
            fy_q       <= '0;
            cos_neg_q  <= 1'b0;
            sin_neg_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_ITER;
                        cnt_q      <= '0;
                        x_q        <= K_INV;
                        y_q        <= '0;
                        z_q        <= w_z_load;
                        cneg_cap_q <= bus.cos_neg_in;
                        sneg_cap_q <= bus.sin_neg_in;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ITER: begin
                    // Once every micro-rotation is done, convert and publish.
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= ST_CONV;
                        fx_q      <= w_fx;
                        fy_q      <= w_fy;
                        cos_neg_q <= cneg_cap_q;
                        sin_neg_q <= sneg_cap_q;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        z_q   <= z_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CONV: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cordic_x = fx_q;
    assign bus.cordic_y = fy_q;
    assign bus.cos_neg  = cos_neg_q;
    assign bus.sin_neg  = sin_neg_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotation_core.sv
`default_nettype none
// ============================================================================
// Module : tb_cordic_rotation_core
// Brief  : Scoreboard bench for the CORDIC core with a plain-arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cordic_rotation_core;

    localparam int ITER = 24;
    localparam int LAT  = ITER + 1;          // load edge to result edge
    localparam logic [31:0] C_PI_2 = 32'h6487ED51;
    localparam real TOL = 1.0 / 1048576.0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_rotation_core_if bus();

    cordic_rotation_core #(.ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        cn;
        logic        sn;
        int          edge_n;
        int          kind;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   atan_t[0:30];

    logic [31:0] h_x = '0, h_y = '0;
    logic        h_cn = 1'b0, h_sn = 1'b0;
    logic        prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input real act, input real lo, input real hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s actual=%0.9f required=[%0.9f,%0.9f]", name, act, lo, hi);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        int e;
        if (b == 32'h0) return 0.0;
        e = int'(b[30:23]) - 127;
        return (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** e);
    endfunction

    function automatic logic [31:0] to_float(input logic [31:0] v);
        int          p;
        logic [31:0] m;
        if (v == 32'h0) return 32'h0;
        p = 31;
        while (!v[p]) p--;
        if (p >= 23) m = v >> (p - 23);
        else         m = v << (23 - p);
        return {1'b0, 8'(127 + p - 30), m[22:0]};
    endfunction

    function automatic exp_t model(input logic [31:0] ang, input logic cn, input logic sn,
                                   input int edge_n, input int kind);
        int   x, y, z, xn, yn;
        exp_t r;
        x = 32'h26DD3B6A;
        y = 0;
        z = (ang > C_PI_2) ? C_PI_2 : ang;
        for (int i = 0; i < ITER; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - atan_t[i];
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + atan_t[i];
            end
            x = xn;
            y = yn;
        end
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        r.x      = to_float(x);
        r.y      = to_float(y);
        r.cn     = cn;
        r.sn     = sn;
        r.edge_n = edge_n;
        r.kind   = kind;
        return r;
    endfunction

    task automatic tol_checks(input int kind);
        real rx, ry;
        rx = f2r(bus.cordic_x);
        ry = f2r(bus.cordic_y);
        if (kind == 1) begin
            chk_rng("zero_cos", rx, 1.0 - TOL, 1.0 + TOL);
            chk_rng("zero_sin", ry, 0.0, TOL);
        end else if (kind == 2) begin
            chk_rng("pi4_cos", rx, 0.70710677 - TOL, 0.70710677 + TOL);
            chk_rng("pi4_sin", ry, 0.70710677 - TOL, 0.70710677 + TOL);
        end else if (kind == 3) begin
            chk_rng("sat_sin", ry, 1.0 - TOL, 1.0 + TOL);
            chk_rng("sat_cos", rx, 0.0, TOL);
            chk("sat_cos_sign", 66'(bus.cordic_x[31]), 66'(0));
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks holding otherwise.
    always @(negedge clk) begin
        if (rst) begin
            h_x = '0; h_y = '0; h_cn = 1'b0; h_sn = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_done", 66'(bus.done), 66'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("cordic_x", 66'(bus.cordic_x), 66'(mon_e.x));
                    chk("cordic_y", 66'(bus.cordic_y), 66'(mon_e.y));
                    chk("cos_neg", 66'(bus.cos_neg), 66'(mon_e.cn));
                    chk("sin_neg", 66'(bus.sin_neg), 66'(mon_e.sn));
                    chk("latency", 66'(cyc - mon_e.edge_n), 66'(LAT));
                    chk("busy_in_done", 66'(bus.busy), 66'(0));
                    chk("busy_before_done", 66'(prev_busy), 66'(1));
                    tol_checks(mon_e.kind);
                    h_x = mon_e.x; h_y = mon_e.y; h_cn = mon_e.cn; h_sn = mon_e.sn;
                end
            end else begin
                chk("hold", {bus.cordic_x, bus.cordic_y, bus.cos_neg, bus.sin_neg},
                    {h_x, h_y, h_cn, h_sn});
            end
            prev_busy = bus.busy;
        end
    end

    // Called just after a rising edge; the request is sampled on the next one.
    task automatic start_op(input logic [31:0] ang, input logic cn, input logic sn, input int kind);
        bus.start      = 1'b1;
        bus.angle      = ang;
        bus.cos_neg_in = cn;
        bus.sin_neg_in = sn;
        sb.push_back(model(ang, cn, sn, cyc + 1, kind));
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_load", 66'(bus.busy), 66'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 66'(sb.size()), 66'(0));
            sb.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #(40000 * 10);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        real t;
        int  d0, e0;
        logic [31:0] a;
        rst = 1'b1;
        bus.start = 1'b0; bus.angle = '0; bus.cos_neg_in = 1'b0; bus.sin_neg_in = 1'b0;
        t = 1.0;
        for (int i = 0; i <= 30; i++) begin
            atan_t[i] = int'($atan(t) * 1073741824.0);
            t = t / 2.0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {bus.cordic_x, bus.cordic_y, bus.cos_neg, bus.sin_neg}, 66'(0));
        chk("rst_busy_done", 66'({bus.busy, bus.done}), 66'(0));
        @(posedge clk); #1;

        start_op(32'h0000_0000, 1'b0, 1'b0, 1); wait_idle();
        start_op(32'h3243_F6A8, 1'b1, 1'b0, 2); wait_idle();
        start_op(32'hFFFF_FFFF, 1'b0, 1'b1, 3); wait_idle();

        // Requests while busy must be dropped.
        idle_cycles(2);
        d0 = done_cnt;
        start_op($urandom_range(0, 32'h6000_0000), 1'b1, 1'b1, 0);
        idle_cycles(3);
        bus.start = 1'b1; bus.angle = 32'h1234_5678; bus.cos_neg_in = 1'b0; bus.sin_neg_in = 1'b0;
        idle_cycles(1);
        bus.start = 1'b0;
        idle_cycles(4);
        bus.start = 1'b1; bus.angle = 32'h0ABC_DEF0;
        idle_cycles(1);
        bus.start = 1'b0;
        wait_idle();
        idle_cycles(30);
        chk("single_done", 66'(done_cnt - d0), 66'(1));

        // Reset in the middle of an operation aborts it.
        start_op(32'h2000_0000, 1'b1, 1'b0, 0);
        idle_cycles(10);
        rst = 1'b1;
        sb.delete();
        idle_cycles(1);
        rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("abort_outputs", {bus.cordic_x, bus.cordic_y, bus.cos_neg, bus.sin_neg}, 66'(0));
        chk("abort_busy", 66'(bus.busy), 66'(0));
        @(posedge clk); #1;
        idle_cycles(30);
        chk("abort_no_done", 66'(done_cnt - d0), 66'(0));
        start_op(32'h1111_1111, 1'b0, 1'b1, 0); wait_idle();

        // Randomised single operations.
        for (int k = 0; k < 40; k++) begin
            idle_cycles($urandom_range(0, 3));
            a = (k % 2 == 0) ? $urandom() : $urandom_range(0, C_PI_2);
            start_op(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            wait_idle();
        end

        // start held high: one acceptance every LAT + 2 edges.
        idle_cycles(2);
        e0 = cyc + 1;
        bus.start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.angle      = $urandom_range(0, C_PI_2);
            bus.cos_neg_in = 1'($urandom_range(0, 1));
            bus.sin_neg_in = 1'($urandom_range(0, 1));
            sb.push_back(model(bus.angle, bus.cos_neg_in, bus.sin_neg_in, e0 + k * (LAT + 2), 0));
            while (cyc < e0 + k * (LAT + 2)) begin @(posedge clk); #1; end
        end
        bus.start = 1'b0;
        wait_idle();

        idle_cycles(5);
        chk("scoreboard_empty", 66'(sb.size()), 66'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
